wash_cycle_ctrl: RTL and testbench
==================================

// Module: wash_cycle_ctrl
// PURPOSE
//  Wash-run controller, directly downstream of the preparation stage.
//  Takes the confirmed balance (0..999) and selected mode on a start pulse,
//  checks and deducts the programme cost, then sequences WASH -> RINSE -> SPIN
//  on a 1 s tick with a remaining-seconds countdown for the 7-seg scanner.
//  Supports pause/resume and abort. Emits done / err_funds pulses.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per 1 s tick (100 MHz board); bench uses 4
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, asynchronous, active-high
//  start      in   1   1-cycle pulse from prep stage: begin programme
//  mode       in   2   programme select, sampled only on accepted start
//  bal_in     in   10  balance from prep stage, 0..999, sampled with start
//  pause_bt   in   1   1-cycle debounced pulse: toggle pause/resume
//  abort      in   1   1-cycle pulse: cancel run, no refund
//  busy       out  1   1 in WASH/RINSE/SPIN/PAUSE
//  paused     out  1   1 in PAUSE only
//  phase      out  3   one-hot 001 wash, 010 rinse, 100 spin; held in PAUSE; 000 IDLE
//  remain_s   out  10  seconds left in whole programme
//  bal_out    out  10  balance after deduction
//  done       out  1   1-cycle pulse on normal completion
//  err_funds  out  1   1-cycle pulse when start rejected for low balance
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, prescaler 0. Reset mid-run clears at once.
//  Programme table (wash/rinse/spin s, cost):
//   mode0 10/5/5 cost 3; mode1 20/10/10 cost 5; mode2 30/15/10 cost 8;
//   mode3 0/0/15 cost 2 (spin only).
//  States: IDLE, WASH, RINSE, SPIN, PAUSE (stores return phase).
//  IDLE + start:
//   - bal_in >= cost: bal_out <= bal_in - cost; remain_s <= total;
//     enter first phase with non-zero duration. Prescaler cleared.
//     busy/phase valid the cycle after start.
//   - bal_in < cost: err_funds = 1 for 1 cycle; stay IDLE; bal_out unchanged.
//  start is ignored outside IDLE. mode/bal_in are ignored except on start.
//  Prescaler: counts 0..TICK_DIV-1 in run states; wrap produces 1-cycle tick.
//   First tick comes TICK_DIV cycles after start.
//  On tick in run state: remain_s -1 and phase counter -1.
//   When the phase counter reaches 0, load next phase and skip zero-duration
//   phases. After SPIN hits 0: done = 1 for that cycle, go to IDLE, phase 000,
//   remain_s 0, bal_out held.
//  pause_bt in run state -> PAUSE. Prescaler and counters freeze; phase held.
//  pause_bt in PAUSE -> back to stored phase; prescaler resumes from frozen value.
//  pause_bt in IDLE is ignored.
//  abort in any non-IDLE state -> IDLE next cycle: remain_s 0, phase 000,
//   no done, bal_out kept (no refund).
//  Priority in the same cycle: rst > abort > pause_bt > tick.
//   A tick coinciding with pause_bt is discarded; the prescaler restarts its
//   count on resume.
//  Arithmetic: remain_s <= 55 fits 10 bits; deduction never underflows,
//   because it is guarded by the compare.
// TESTING (TICK_DIV=4)
//  1 bal_in=10,mode=1,start -> bal_out=5, remain_s=40, phase=001;
//    after 20 ticks phase=010, remain_s=20; after 40 ticks done 1 cycle, busy=0.
//  2 bal_in=7,mode=2,start -> err_funds 1 cycle, busy=0, bal_out unchanged.
//  3 bal_in=2,mode=3,start -> bal_out=0, phase=100 directly, remain_s=15, done after 60 clk.
//  4 mode0, pause_bt after 3 ticks -> remain_s=17 frozen for 100 clk, paused=1;
//    pause_bt again -> finishes after 17 more ticks.
//  5 mode1 in rinse, abort and pause_bt in the same cycle -> IDLE, remain_s=0, no done.
//  6 rst pulsed mid-spin -> all outputs 0 immediately; start is accepted afterwards.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Wash-run controller: accepts a paid programme on start, then steps
// WASH -> RINSE -> SPIN on a 1 s tick with a whole-programme countdown.
// Supports pause/resume and abort; emits done / err_funds pulses.
module wash_cycle_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [9:0] bal_in,
  input  logic       pause_bt,
  input  logic       abort,
  output logic       busy,
  output logic       paused,
  output logic [2:0] phase,
  output logic [9:0] remain_s,
  output logic [9:0] bal_out,
  output logic       done,
  output logic       err_funds
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WASH  = 3'd1;
  localparam logic [2:0] S_RINSE = 3'd2;
  localparam logic [2:0] S_SPIN  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  // Seconds spent in a given run state for a programme.
  function automatic logic [5:0] phase_dur(input logic [1:0] m, input logic [2:0] st);
    logic [5:0] d;
    d = 6'd0;
    case (m)
      2'd0: d = (st == S_WASH) ? 6'd10 : (st == S_RINSE) ? 6'd5  : (st == S_SPIN) ? 6'd5  : 6'd0;
      2'd1: d = (st == S_WASH) ? 6'd20 : (st == S_RINSE) ? 6'd10 : (st == S_SPIN) ? 6'd10 : 6'd0;
      2'd2: d = (st == S_WASH) ? 6'd30 : (st == S_RINSE) ? 6'd15 : (st == S_SPIN) ? 6'd10 : 6'd0;
      default: d = (st == S_SPIN) ? 6'd15 : 6'd0;
    endcase
    return d;
  endfunction

  function automatic logic [9:0] prog_total(input logic [1:0] m);
    case (m)
      2'd0:    return 10'd20;
      2'd1:    return 10'd40;
      2'd2:    return 10'd55;
      default: return 10'd15;
    endcase
  endfunction

  function automatic logic [9:0] prog_cost(input logic [1:0] m);
    case (m)
      2'd0:    return 10'd3;
      2'd1:    return 10'd5;
      2'd2:    return 10'd8;
      default: return 10'd2;
    endcase
  endfunction

  // Next run state after st, skipping zero-length phases; every programme
  // has a non-zero spin, so spin is always reached. After spin comes IDLE.
  function automatic logic [2:0] next_run(input logic [1:0] m, input logic [2:0] st);
    case (st)
      S_IDLE:  return (phase_dur(m, S_WASH) != 6'd0)  ? S_WASH :
                      (phase_dur(m, S_RINSE) != 6'd0) ? S_RINSE : S_SPIN;
      S_WASH:  return (phase_dur(m, S_RINSE) != 6'd0) ? S_RINSE : S_SPIN;
      S_RINSE: return S_SPIN;
      default: return S_IDLE;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [2:0]    ret_q, ret_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    phcnt_q, phcnt_d;
  logic [9:0]    remain_q, remain_d;
  logic [9:0]    bal_q, bal_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          run;
  logic          tick;
  logic [2:0]    nxt_st;
  logic [2:0]    disp_st;

  assign run  = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN);
  assign tick = run && (presc_q == PRESC_MAX);

  // Next-state logic; priority is abort > pause_bt > tick.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    phcnt_d  = phcnt_q;
    remain_d = remain_q;
    bal_d    = bal_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    nxt_st   = next_run(mode_q, state_q);

    if (state_q == S_IDLE) begin
      if (start) begin
        if (bal_in >= prog_cost(mode)) begin
          bal_d    = bal_in - prog_cost(mode);
          remain_d = prog_total(mode);
          mode_d   = mode;
          state_d  = next_run(mode, S_IDLE);
          phcnt_d  = phase_dur(mode, next_run(mode, S_IDLE));
          presc_d  = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (abort) begin
      state_d  = S_IDLE;
      remain_d = 10'd0;
      phcnt_d  = 6'd0;
      presc_d  = '0;
    end else if (pause_bt) begin
      if (state_q == S_PAUSE) begin
        state_d = ret_q;
      end else begin
        ret_d   = state_q;
        state_d = S_PAUSE;
        // A tick landing on the pause edge is dropped; counting restarts.
        if (tick) presc_d = '0;
      end
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        remain_d = remain_q - 10'd1;
        if (phcnt_q == 6'd1) begin
          state_d = nxt_st;
          if (nxt_st == S_IDLE) begin
            phcnt_d  = 6'd0;
            remain_d = 10'd0;
            done_d   = 1'b1;
          end else begin
            phcnt_d = phase_dur(mode_q, nxt_st);
          end
        end else begin
          phcnt_d = phcnt_q - 6'd1;
        end
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      mode_q   <= 2'd0;
      presc_q  <= '0;
      phcnt_q  <= 6'd0;
      remain_q <= 10'd0;
      bal_q    <= 10'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      phcnt_q  <= phcnt_d;
      remain_q <= remain_d;
      bal_q    <= bal_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign disp_st = (state_q == S_PAUSE) ? ret_q : state_q;

  // One-hot phase display; PAUSE shows the phase it will return to.
  always_comb begin
    phase = 3'b000;
    case (disp_st)
      S_WASH:  phase = 3'b001;
      S_RINSE: phase = 3'b010;
      S_SPIN:  phase = 3'b100;
      default: phase = 3'b000;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign paused    = (state_q == S_PAUSE);
  assign remain_s  = remain_q;
  assign bal_out   = bal_q;
  assign done      = done_q;
  assign err_funds = err_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl with TICK_DIV = 4.
module tb_wash_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [9:0] bal_in = 10'd0;
  logic       pause_bt = 1'b0;
  logic       abort = 1'b0;
  logic       busy, paused, done, err_funds;
  logic [2:0] phase;
  logic [9:0] remain_s, bal_out;

  int checks = 0;
  int errors = 0;

  wash_cycle_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bal_in(bal_in),
    .pause_bt(pause_bt), .abort(abort), .busy(busy), .paused(paused),
    .phase(phase), .remain_s(remain_s), .bal_out(bal_out), .done(done),
    .err_funds(err_funds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [9:0] bal;
    logic       exp_err;
    logic [9:0] exp_bal;
    logic [9:0] exp_rem;
    logic [2:0] exp_ph;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [9:0] b);
    mode = m;
    bal_in = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    int hit;

    tbl[0] = '{2'd0, 10'd3,   1'b0, 10'd0,   10'd20, 3'b001};
    tbl[1] = '{2'd1, 10'd999, 1'b0, 10'd994, 10'd40, 3'b001};
    tbl[2] = '{2'd2, 10'd8,   1'b0, 10'd0,   10'd55, 3'b001};
    tbl[3] = '{2'd3, 10'd2,   1'b0, 10'd0,   10'd15, 3'b100};
    tbl[4] = '{2'd2, 10'd7,   1'b1, 10'd0,   10'd0,  3'b000};
    tbl[5] = '{2'd3, 10'd500, 1'b0, 10'd498, 10'd15, 3'b100};
    tbl[6] = '{2'd1, 10'd4,   1'b1, 10'd498, 10'd0,  3'b000};
    tbl[7] = '{2'd0, 10'd0,   1'b1, 10'd498, 10'd0,  3'b000};

    // Reset state
    step();
    chk("reset_outputs", int'({busy, paused, phase, remain_s, bal_out, done, err_funds}), 0);
    rst = 1'b0;
    step();

    // pause_bt in IDLE is ignored
    pause_bt = 1'b1;
    step();
    pause_bt = 1'b0;
    chk("idle_pause_ignored", int'({busy, paused}), 0);

    // Table: start acceptance / rejection, then abort each accepted run
    for (int i = 0; i < 8; i++) begin
      do_start(tbl[i].mode, tbl[i].bal);
      chk($sformatf("tbl%0d_err", i), int'(err_funds), int'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(!tbl[i].exp_err));
      chk($sformatf("tbl%0d_bal", i), int'(bal_out), int'(tbl[i].exp_bal));
      chk($sformatf("tbl%0d_rem", i), int'(remain_s), int'(tbl[i].exp_rem));
      chk($sformatf("tbl%0d_phase", i), int'(phase), int'(tbl[i].exp_ph));
      if (!tbl[i].exp_err) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk($sformatf("tbl%0d_abort", i), int'({busy, done, phase, remain_s}), 0);
        chk($sformatf("tbl%0d_abort_bal", i), int'(bal_out), int'(tbl[i].exp_bal));
      end else begin
        step();
        chk($sformatf("tbl%0d_err_pulse_end", i), int'(err_funds), 0);
      end
    end

    // Test 1: mode1 full run, start while busy ignored
    do_start(2'd1, 10'd10);
    chk("t1_bal", int'(bal_out), 5);
    chk("t1_rem", int'(remain_s), 40);
    chk("t1_phase", int'(phase), 1);
    do_start(2'd3, 10'd999);
    chk("t1_busy_start_bal", int'(bal_out), 5);
    chk("t1_busy_start_phase", int'(phase), 1);
    repeat (79) step();
    chk("t1_rinse_phase", int'(phase), 2);
    chk("t1_rinse_rem", int'(remain_s), 20);
    repeat (79) step();
    chk("t1_before_done", int'({done, busy, remain_s}), int'({1'b0, 1'b1, 10'd1}));
    step();
    chk("t1_done", int'({done, busy, phase, remain_s}), int'({1'b1, 1'b0, 3'b000, 10'd0}));
    chk("t1_bal_held", int'(bal_out), 5);
    step();
    chk("t1_done_pulse_end", int'(done), 0);

    // Test 3: spin-only programme, done 60 clocks after start
    do_start(2'd3, 10'd2);
    chk("t3_start", int'({bal_out, phase, remain_s}), int'({10'd0, 3'b100, 10'd15}));
    hit = 0;
    for (int k = 1; k <= 100 && hit == 0; k++) begin
      step();
      if (k == 30) chk("t3_mid", int'({phase, remain_s}), int'({3'b100, 10'd8}));
      if (done) hit = k;
    end
    chk("t3_done_latency", hit, 60);

    // Test 4: pause after 3 ticks, frozen, then resume finishes 17 ticks later
    do_start(2'd0, 10'd3);
    repeat (12) step();
    chk("t4_rem_before_pause", int'(remain_s), 17);
    pause_bt = 1'b1;
    step();
    pause_bt = 1'b0;
    chk("t4_paused", int'({busy, paused, phase, remain_s}), int'({1'b1, 1'b1, 3'b001, 10'd17}));
    bad = 0;
    repeat (100) begin
      step();
      if (remain_s != 10'd17 || !paused || phase != 3'b001) bad++;
    end
    chk("t4_frozen", bad, 0);
    pause_bt = 1'b1;
    step();
    pause_bt = 1'b0;
    chk("t4_resumed", int'({paused, phase, remain_s}), int'({1'b0, 3'b001, 10'd17}));
    hit = 0;
    for (int k = 1; k <= 200 && hit == 0; k++) begin
      step();
      if (done) hit = k;
    end
    chk("t4_done_latency", hit, 68);

    // Test 5: abort and pause_bt together in rinse
    do_start(2'd1, 10'd10);
    repeat (84) step();
    chk("t5_in_rinse", int'(phase), 2);
    abort = 1'b1;
    pause_bt = 1'b1;
    step();
    abort = 1'b0;
    pause_bt = 1'b0;
    chk("t5_abort", int'({busy, paused, phase, remain_s, done}), 0);
    chk("t5_bal_kept", int'(bal_out), 5);
    n = 0;
    repeat (50) begin
      step();
      if (done || busy) n++;
    end
    chk("t5_no_done", n, 0);

    // Test 6: asynchronous reset mid-spin, then a fresh start
    do_start(2'd3, 10'd20);
    repeat (20) step();
    chk("t6_spin", int'({phase, bal_out}), int'({3'b100, 10'd18}));
    #1 rst = 1'b1;
    #1;
    chk("t6_async_clear", int'({busy, paused, phase, remain_s, bal_out, done, err_funds}), 0);
    #1 rst = 1'b0;
    step();
    do_start(2'd0, 10'd5);
    chk("t6_restart", int'({busy, phase, remain_s, bal_out}), int'({1'b1, 3'b001, 10'd20, 10'd2}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
